lcd_bus_rx: RTL and testbench

Receiving end of the 8-bit HD44780-style LCD write bus (en, rs, wr, data[7:0]). It decodes command and character writes and maintains a 32-character display RAM image, cursor address and display-control flags. A registered read port and status outputs let the design be self-checked in simulation or mirrored to another display path without a physical LCD. Sits on the same clock as the bus driver.

---
 rtl/lcd_bus_rx_if.sv | 10 +
 rtl/lcd_bus_rx.sv | 193 +++++++++++++++++++
 tb/tb_lcd_bus_rx.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_rx_if.sv
// LCD write-bus bundle (en, rs, wr, data) between a bus driver and lcd_bus_rx.
interface lcd_bus_rx_if;
  logic       en;
  logic       rs;
  logic       wr;
  logic [7:0] data;

  modport master (output en, rs, wr, data);
  modport slave  (input  en, rs, wr, data);
endinterface

// File: rtl/lcd_bus_rx.sv
// HD44780-style LCD write-bus receiver: 32-char RAM image, cursor, display flags.
// Optional LCD_RX_BUSY_EN adds a post-write busy hold of BUSY_CYCLES cycles.
module lcd_bus_rx #(
`ifdef LCD_RX_BUSY_EN
  parameter int unsigned BUSY_CYCLES = 40,
`endif
  parameter logic [7:0]  CHAR_BLANK  = 8'h20
) (
  input  logic             clk,
  input  logic             rst,
  lcd_bus_rx_if.slave      bus,
  input  logic [4:0]       rd_addr,
  output logic [7:0]       rd_data,
  output logic [4:0]       cursor_addr,
  output logic             display_on,
  output logic             cursor_on,
  output logic             blink_on,
  output logic             busy,
  output logic             cmd_valid,
  output logic             data_valid,
  output logic             overrun
);
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned DW    = 8;

`ifdef LCD_RX_BUSY_EN
  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_HOLD} state_e;
  logic [DW-1:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_FILL} state_e;
`endif

  state_e        state_q, state_d;
  logic          s1_en_q, s1_rs_q, s1_wr_q, s2_en_q;
  logic [DW-1:0] s1_data_q;
  logic [AW-1:0] fill_idx_q, fill_idx_d;
  logic [AW-1:0] cursor_q, cursor_d;
  logic          inc_q, inc_d;
  logic          disp_q, disp_d, curs_q, curs_d, blink_q, blink_d;
  logic          cmd_valid_q, cmd_valid_d, data_valid_q, data_valid_d;
  logic          overrun_q, overrun_d;
  logic [DW-1:0] rd_data_q;
  logic [DW-1:0] ram_q [DEPTH];

  logic          busy_c, wr_evt_c, ram_we_c;
  logic [AW-1:0] ram_waddr_c;
  logic [DW-1:0] ram_wdata_c;

  assign busy_c   = (state_q != ST_IDLE);
  assign wr_evt_c = s2_en_q & ~s1_en_q & s1_wr_q;

  // Bus input stage and all state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_en_q      <= 1'b0;
      s1_rs_q      <= 1'b0;
      s1_wr_q      <= 1'b0;
      s1_data_q    <= '0;
      s2_en_q      <= 1'b0;
      state_q      <= ST_FILL;
      fill_idx_q   <= '0;
      cursor_q     <= '0;
      inc_q        <= 1'b1;
      disp_q       <= 1'b0;
      curs_q       <= 1'b0;
      blink_q      <= 1'b0;
      cmd_valid_q  <= 1'b0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      rd_data_q    <= '0;
`ifdef LCD_RX_BUSY_EN
      cnt_q        <= '0;
`endif
    end else begin
      s1_en_q      <= bus.en;
      s1_rs_q      <= bus.rs;
      s1_wr_q      <= bus.wr;
      s1_data_q    <= bus.data;
      s2_en_q      <= s1_en_q;
      state_q      <= state_d;
      fill_idx_q   <= fill_idx_d;
      cursor_q     <= cursor_d;
      inc_q        <= inc_d;
      disp_q       <= disp_d;
      curs_q       <= curs_d;
      blink_q      <= blink_d;
      cmd_valid_q  <= cmd_valid_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
      rd_data_q    <= ram_q[rd_addr];
`ifdef LCD_RX_BUSY_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  // Display RAM has no reset; contents are defined once the fill completes
  always_ff @(posedge clk) begin
    if (ram_we_c) ram_q[ram_waddr_c] <= ram_wdata_c;
  end

  // Next-state, command decode and RAM write selection
  always_comb begin
    state_d      = state_q;
    fill_idx_d   = fill_idx_q;
    cursor_d     = cursor_q;
    inc_d        = inc_q;
    disp_d       = disp_q;
    curs_d       = curs_q;
    blink_d      = blink_q;
    cmd_valid_d  = 1'b0;
    data_valid_d = 1'b0;
    overrun_d    = overrun_q;
    ram_we_c     = 1'b0;
    ram_waddr_c  = fill_idx_q;
    ram_wdata_c  = CHAR_BLANK;
`ifdef LCD_RX_BUSY_EN
    cnt_d        = cnt_q;
`endif

    case (state_q)
      ST_FILL: begin
        ram_we_c   = 1'b1;
        fill_idx_d = fill_idx_q + AW'(1);
        if (fill_idx_q == AW'(DEPTH - 1)) begin
`ifdef LCD_RX_BUSY_EN
          state_d = ST_HOLD;
          cnt_d   = DW'(BUSY_CYCLES);
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef LCD_RX_BUSY_EN
      ST_HOLD: begin
        cnt_d = cnt_q - DW'(1);
        if (cnt_q <= DW'(1)) state_d = ST_IDLE;
      end
`endif
      default: ;
    endcase

    if (wr_evt_c) begin
      if (busy_c) begin
        overrun_d = 1'b1;
      end else begin
`ifdef LCD_RX_BUSY_EN
        state_d = ST_HOLD;
        cnt_d   = DW'(BUSY_CYCLES);
`endif
        if (s1_rs_q) begin
          ram_we_c     = 1'b1;
          ram_waddr_c  = cursor_q;
          ram_wdata_c  = s1_data_q;
          cursor_d     = inc_q ? cursor_q + AW'(1) : cursor_q - AW'(1);
          data_valid_d = 1'b1;
        end else begin
          cmd_valid_d = 1'b1;
          // Highest set bit selects the command
          if (s1_data_q[7]) begin
            cursor_d = {s1_data_q[6], s1_data_q[3:0]};
          end else if (s1_data_q[6:4] != 3'b000) begin
            cursor_d = cursor_q;
          end else if (s1_data_q[3]) begin
            disp_d  = s1_data_q[2];
            curs_d  = s1_data_q[1];
            blink_d = s1_data_q[0];
          end else if (s1_data_q[2]) begin
            inc_d = s1_data_q[1];
          end else if (s1_data_q[1]) begin
            cursor_d = '0;
          end else if (s1_data_q[0]) begin
            cursor_d   = '0;
            inc_d      = 1'b1;
            fill_idx_d = '0;
            state_d    = ST_FILL;
          end
        end
      end
    end
  end

  assign rd_data     = rd_data_q;
  assign cursor_addr = cursor_q;
  assign display_on  = disp_q;
  assign cursor_on   = curs_q;
  assign blink_on    = blink_q;
  assign busy        = busy_c;
  assign cmd_valid   = cmd_valid_q;
  assign data_valid  = data_valid_q;
  assign overrun     = overrun_q;
endmodule

// File: tb/tb_lcd_bus_rx.sv
// Self-checking bench for lcd_bus_rx: vector table, corner sequences, random writes vs model.
module tb_lcd_bus_rx;
`ifdef LCD_RX_BUSY_EN
  localparam int HOLD = 4;
`else
  localparam int HOLD = 0;
`endif
  localparam int FILL = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic [4:0] cursor_addr;
  logic       display_on, cursor_on, blink_on, busy, cmd_valid, data_valid, overrun;

  lcd_bus_rx_if bus_if ();

`ifdef LCD_RX_BUSY_EN
  lcd_bus_rx #(.BUSY_CYCLES(4), .CHAR_BLANK(8'h20)) dut (
`else
  lcd_bus_rx #(.CHAR_BLANK(8'h20)) dut (
`endif
    .clk(clk), .rst(rst), .bus(bus_if), .rd_addr(rd_addr), .rd_data(rd_data),
    .cursor_addr(cursor_addr), .display_on(display_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .busy(busy), .cmd_valid(cmd_valid),
    .data_valid(data_valid), .overrun(overrun));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] m_ram [32];
  logic [4:0] m_cur;
  logic       m_inc, m_disp, m_curs, m_blink, m_ovr;

  typedef struct {
    logic       wr;
    logic       rs;
    logic [7:0] d;
    logic       e_cmd;
    logic       e_dat;
    logic [4:0] e_cur;
    logic [2:0] e_flags;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
    m_cur = 0; m_inc = 1; m_disp = 0; m_curs = 0; m_blink = 0; m_ovr = 0;
  endtask

  // Effect of one accepted transaction, expressed by command ranges
  task automatic model_write(input logic wr_v, input logic rs_v, input logic [7:0] d,
                             output logic e_cmd, output logic e_dat, output int e_busy);
    e_cmd = 0; e_dat = 0; e_busy = 0;
    if (!wr_v) return;
    e_busy = HOLD;
    if (rs_v) begin
      e_dat = 1;
      m_ram[m_cur] = d;
      m_cur = m_inc ? m_cur + 5'd1 : m_cur - 5'd1;
    end else begin
      e_cmd = 1;
      if (d == 8'h01) begin
        m_cur = 0; m_inc = 1; e_busy = FILL + HOLD;
        for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
      end else if (d == 8'h02 || d == 8'h03) m_cur = 0;
      else if (d >= 8'h04 && d <= 8'h07) m_inc = d[1];
      else if (d >= 8'h08 && d <= 8'h0F) begin
        m_disp = d[2]; m_curs = d[1]; m_blink = d[0];
      end else if (d >= 8'h80) m_cur = 5'(((d >> 6) & 8'd1) * 16 + (d & 8'h0F));
    end
  endtask

  task automatic bus_pulse(input logic wr_v, input logic rs_v, input logic [7:0] d);
    @(negedge clk); bus_if.en = 1; bus_if.wr = wr_v; bus_if.rs = rs_v; bus_if.data = d;
    @(negedge clk); bus_if.en = 0;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy && n < 300) begin n++; @(negedge clk); end
  endtask

  task automatic do_write(input string nm, input logic wr_v, input logic rs_v, input logic [7:0] d);
    logic ec, ed; int eb, n;
    model_write(wr_v, rs_v, d, ec, ed, eb);
    bus_pulse(wr_v, rs_v, d);
    @(negedge clk); @(negedge clk);
    chk({nm, ".cmd_valid"}, 32'(cmd_valid), 32'(ec));
    chk({nm, ".data_valid"}, 32'(data_valid), 32'(ed));
    chk({nm, ".cursor"}, 32'(cursor_addr), 32'(m_cur));
    chk({nm, ".flags"}, 32'({display_on, cursor_on, blink_on}), 32'({m_disp, m_curs, m_blink}));
    chk({nm, ".overrun"}, 32'(overrun), 32'(m_ovr));
    busy_len(n);
    chk({nm, ".busy_len"}, 32'(n), 32'(eb));
    @(negedge clk);
    chk({nm, ".pulse_end"}, 32'({cmd_valid, data_valid}), 32'(0));
  endtask

  task automatic chk_ram(input string nm, input int idx, input logic [7:0] exp);
    @(negedge clk); rd_addr = 5'(idx);
    @(negedge clk);
    chk($sformatf("%s[%0d]", nm, idx), 32'(rd_data), 32'(exp));
  endtask

  vec_t vecs [10];

  initial begin
    int n;
    logic c0, d0; int b0;
    logic [4:0] c;
    logic [7:0] keep;

    vecs[0] = '{1, 0, 8'h0C, 1, 0, 5'd0,  3'b100};
    vecs[1] = '{1, 1, 8'h32, 0, 1, 5'd1,  3'b100};
    vecs[2] = '{1, 1, 8'h35, 0, 1, 5'd2,  3'b100};
    vecs[3] = '{0, 1, 8'h99, 0, 0, 5'd2,  3'b100};
    vecs[4] = '{1, 0, 8'hCF, 1, 0, 5'd31, 3'b100};
    vecs[5] = '{1, 1, 8'h41, 0, 1, 5'd0,  3'b100};
    vecs[6] = '{1, 1, 8'h42, 0, 1, 5'd1,  3'b100};
    vecs[7] = '{1, 0, 8'h04, 1, 0, 5'd1,  3'b100};
    vecs[8] = '{1, 0, 8'h80, 1, 0, 5'd0,  3'b100};
    vecs[9] = '{1, 1, 8'h58, 0, 1, 5'd31, 3'b100};

    bus_if.en = 0; bus_if.rs = 0; bus_if.wr = 0; bus_if.data = 0;
    rd_addr = 0; rst = 1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst.busy", 32'(busy), 32'(1));
    chk("rst.cursor", 32'(cursor_addr), 32'(0));
    chk("rst.flags", 32'({display_on, cursor_on, blink_on}), 32'(0));
    chk("rst.overrun", 32'(overrun), 32'(0));
    chk("rst.pulses", 32'({cmd_valid, data_valid}), 32'(0));
    chk("rst.rd_data", 32'(rd_data), 32'(0));
    rst = 0;
    busy_len(n);
    chk("rst.busy_len", 32'(n), 32'(FILL + HOLD));
    for (int i = 0; i < 32; i++) chk_ram("rst.ram", i, 8'h20);

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      do_write($sformatf("vec%0d", i), vecs[i].wr, vecs[i].rs, vecs[i].d);
      chk($sformatf("vec%0d.tbl_cur", i), 32'(cursor_addr), 32'(vecs[i].e_cur));
      chk($sformatf("vec%0d.tbl_flags", i), 32'({display_on, cursor_on, blink_on}), 32'(vecs[i].e_flags));
    end
    chk_ram("tbl.ram", 0, 8'h58);
    chk_ram("tbl.ram", 1, 8'h35);
    chk_ram("tbl.ram", 31, 8'h41);

    // Clear, then a character write while the fill is running
    bus_pulse(1, 0, 8'h01);
    @(negedge clk); @(negedge clk);
    chk("clr.cmd_valid", 32'(cmd_valid), 32'(1));
    chk("clr.busy", 32'(busy), 32'(1));
    model_write(1, 0, 8'h01, c0, d0, b0);
    bus_pulse(1, 1, 8'h43);
    @(negedge clk); @(negedge clk);
    m_ovr = 1;
    chk("clr.drop_dv", 32'(data_valid), 32'(0));
    chk("clr.overrun", 32'(overrun), 32'(1));
    busy_len(n);
    chk("clr.idle", 32'(busy), 32'(0));
    chk("clr.cursor", 32'(cursor_addr), 32'(0));
    for (int i = 0; i < 32; i++) chk_ram("clr.ram", i, 8'h20);

    // Two character writes three cycles apart
    c = m_cur;
    keep = m_ram[5'(c + 5'd1)];
    bus_pulse(1, 1, 8'hA1);
    @(negedge clk);
    bus_pulse(1, 1, 8'hA2);
    repeat (3) @(negedge clk);
    busy_len(n);
    model_write(1, 1, 8'hA1, c0, d0, b0);
`ifdef LCD_RX_BUSY_EN
    chk("b2b.cursor", 32'(cursor_addr), 32'(5'(c + 5'd1)));
    chk_ram("b2b.ram", 32'(5'(c + 5'd1)), keep);
`else
    model_write(1, 1, 8'hA2, c0, d0, b0);
    chk("b2b.cursor", 32'(cursor_addr), 32'(5'(c + 5'd2)));
    chk_ram("b2b.ram", 32'(5'(c + 5'd1)), 8'hA2);
`endif
    chk_ram("b2b.ram", 32'(c), 8'hA1);
    chk("b2b.overrun", 32'(overrun), 32'(m_ovr));

    // Randomized writes against the model
    for (int i = 0; i < 40; i++) begin
      logic wv, rv; logic [7:0] dv;
      wv = ($urandom_range(0, 7) != 0);
      rv = $urandom_range(0, 1) == 1;
      dv = 8'($urandom_range(0, 255));
      if (!rv && $urandom_range(0, 15) == 0) dv = 8'h01;
      do_write($sformatf("rnd%0d", i), wv, rv, dv);
    end
    for (int i = 0; i < 32; i++) chk_ram("rnd.ram", i, m_ram[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
